// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer note arbiter.
//   NOTE_W / NOTE_REST : note code width and the rest (silence) code
//   SRC_*              : source indices (beep, free-play, learn, auto)
//   NUM_SRC / SRC_W    : number of sources and width of a source index
//   arb_state_e        : arbiter FSM states
//   src_onehot()       : source index to one-hot grant vector
package buzzer_pkg;

    localparam int unsigned NOTE_W    = 5;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SRC_W   = 2;

    localparam logic [SRC_W-1:0] SRC_BEEP  = 2'd0;
    localparam logic [SRC_W-1:0] SRC_FREE  = 2'd1;
    localparam logic [SRC_W-1:0] SRC_LEARN = 2'd2;
    localparam logic [SRC_W-1:0] SRC_AUTO  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } arb_state_e;

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] src);
        logic [NUM_SRC-1:0] oh;
        oh      = '0;
        oh[src] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/buzzer_arb_pick.sv
// Combinational winner selection for the buzzer arbiter.
//   eff        in  4 : effective requests (req & src_en)
//   last_owner in  2 : most recent owner, round-robin search origin
//   owner      in  2 : current owner, used for the preemption decision
//   any        out 1 : at least one effective request
//   winner     out 2 : selected source
//   preempt    out 1 : a request that may preempt the current owner is present
// Macro BUZZER_ARB_RR_EN: sources 1..3 rotate round-robin, beep keeps absolute
// priority and is the only preemptor. Undefined: fixed priority, lowest index wins.
module buzzer_arb_pick
    import buzzer_pkg::*;
(
    input  logic [NUM_SRC-1:0] eff,
    input  logic [SRC_W-1:0]   last_owner,
    input  logic [SRC_W-1:0]   owner,
    output logic               any,
    output logic [SRC_W-1:0]   winner,
    output logic               preempt
);

    assign any = |eff;

`ifdef BUZZER_ARB_RR_EN
    always_comb begin
        winner  = SRC_BEEP;
        preempt = eff[SRC_BEEP] && (owner != SRC_BEEP);
        if (!eff[SRC_BEEP]) begin
            // Search starts just after the last owner, wrapping 3 -> 1.
            unique case (last_owner)
                SRC_FREE: begin
                    if (eff[2])      winner = SRC_LEARN;
                    else if (eff[3]) winner = SRC_AUTO;
                    else if (eff[1]) winner = SRC_FREE;
                end
                SRC_LEARN: begin
                    if (eff[3])      winner = SRC_AUTO;
                    else if (eff[1]) winner = SRC_FREE;
                    else if (eff[2]) winner = SRC_LEARN;
                end
                default: begin
                    if (eff[1])      winner = SRC_FREE;
                    else if (eff[2]) winner = SRC_LEARN;
                    else if (eff[3]) winner = SRC_AUTO;
                end
            endcase
        end
    end
`else
    always_comb begin
        winner = SRC_BEEP;
        if (eff[0])      winner = SRC_BEEP;
        else if (eff[1]) winner = SRC_FREE;
        else if (eff[2]) winner = SRC_LEARN;
        else if (eff[3]) winner = SRC_AUTO;
    end

    // Only strictly lower indices outrank the owner.
    always_comb begin
        preempt = 1'b0;
        unique case (owner)
            SRC_BEEP:  preempt = 1'b0;
            SRC_FREE:  preempt = eff[0];
            SRC_LEARN: preempt = |eff[1:0];
            default:   preempt = |eff[2:0];
        endcase
    end
`endif

    logic unused_last;
    assign unused_last = ^last_owner;

endmodule

// File: rtl/buzzer_arbiter.sv
// Shares the buzzer note input between beep, free-play, learn and auto sources.
// Enforces a minimum note hold per owner and a forced silent gap on every
// ownership change.
//   clk      in  1  : system clock
//   rst_n    in  1  : asynchronous active-low reset
//   req      in  4  : per-source request (0 beep, 1 free, 2 learn, 3 auto)
//   note_in  in  20 : source i note at [5i+4:5i]
//   src_en   in  4  : per-source enable; disabled requests are ignored
//   pause    in  1  : freeze state/counters and mute
//   note_out out 5  : registered note to the buzzer
//   grant    out 4  : one-hot owner, 0 when none
//   busy     out 1  : high in GRANT or GAP
// Macro BUZZER_ARB_RR_EN selects round-robin among sources 1..3 (see buzzer_arb_pick).
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int unsigned MIN_HOLD_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES      = 500_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*NOTE_W-1:0]  note_in,
    input  logic [NUM_SRC-1:0]         src_en,
    input  logic                       pause,
    output logic [NOTE_W-1:0]          note_out,
    output logic [NUM_SRC-1:0]         grant,
    output logic                       busy
);

    localparam int unsigned CNT_MAX = (MIN_HOLD_CYCLES > GAP_CYCLES) ? MIN_HOLD_CYCLES
                                                                      : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e         state_q;
    logic [SRC_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NOTE_W-1:0]  note_last_q;

    logic [NUM_SRC-1:0] eff;
    logic [NOTE_W-1:0]  notes [NUM_SRC];
    logic               any;
    logic [SRC_W-1:0]   winner;
    logic               preempt;

    assign eff = req & src_en;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_notes
        assign notes[g] = note_in[NOTE_W*g +: NOTE_W];
    end

    buzzer_arb_pick u_pick (
        .eff        (eff),
        .last_owner (owner_q),
        .owner      (owner_q),
        .any        (any),
        .winner     (winner),
        .preempt    (preempt)
    );

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= SRC_BEEP;
            cnt_q       <= '0;
            note_last_q <= NOTE_REST;
            note_out    <= NOTE_REST;
            grant       <= '0;
        end else if (pause) begin
            // Everything freezes except the output, which goes silent.
            note_out <= NOTE_REST;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any) begin
                        state_q     <= StGrant;
                        owner_q     <= winner;
                        grant       <= src_onehot(winner);
                        note_out    <= notes[winner];
                        note_last_q <= notes[winner];
                        cnt_q       <= HOLD_LOAD;
                    end
                end
                StGrant: begin
                    if (!src_en[owner_q] || (!eff[owner_q] && cnt_q == '0) ||
                        (eff[owner_q] && preempt && cnt_q == '0)) begin
                        state_q  <= StGap;
                        grant    <= '0;
                        note_out <= NOTE_REST;
                        cnt_q    <= GAP_LOAD;
                    end else if (!eff[owner_q]) begin
                        // Owner released early: keep the last note until the hold expires.
                        note_out <= note_last_q;
                        cnt_q    <= cnt_q - CNT_ONE;
                    end else begin
                        note_out    <= notes[owner_q];
                        note_last_q <= notes[owner_q];
                        if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (any) begin
                        state_q     <= StGrant;
                        owner_q     <= winner;
                        grant       <= src_onehot(winner);
                        note_out    <= notes[winner];
                        note_last_q <= notes[winner];
                        cnt_q       <= HOLD_LOAD;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    grant    <= '0;
                    note_out <= NOTE_REST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
module tb_buzzer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [19:0] note_in;
    logic [3:0]  src_en;
    logic        pause;
    logic [4:0]  note_out;
    logic [3:0]  grant;
    logic        busy;

    int n_checks;
    int n_errors;

    buzzer_arbiter #(
        .MIN_HOLD_CYCLES (8),
        .GAP_CYCLES      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .note_in  (note_in),
        .src_en   (src_en),
        .pause    (pause),
        .note_out (note_out),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; sampling and driving both happen on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_notes(input logic [4:0] n0, input logic [4:0] n1,
                             input logic [4:0] n2, input logic [4:0] n3);
        note_in = {n3, n2, n1, n0};
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        pause   = 1'b0;
        src_en  = 4'b1111;
        note_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp2;

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_note", note_out, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Basic grant, one-cycle latency
        set_notes(0, 12, 0, 0);
        req = 4'b0010;
        tick();
        check("s1_grant", grant, 4'b0010);
        check("s1_note", note_out, 12);
        check("s1_busy", busy, 1);
        set_notes(0, 17, 0, 0);
        tick();
        check("s1_note_chg", note_out, 17);
        // Asynchronous reset silences mid-note
        #2 rst_n = 1'b0;
        #1;
        check("s1_async_note", note_out, 0);
        check("s1_async_grant", grant, 0);

        // Early release: hold then gap then idle
        do_reset();
        set_notes(0, 0, 0, 8);
        req = 4'b1000;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check("s2_note", note_out, (c <= 8) ? 8 : 0);
            check("s2_grant", grant, (c <= 8) ? 4'b1000 : 4'b0000);
            check("s2_busy", busy, (c <= 12) ? 1 : 0);
            if (c == 2) req = 4'b0000;
        end

        // Preemption by beep after hold
        do_reset();
        set_notes(20, 0, 0, 8);
        req = 4'b1000;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check("s3_note", note_out, (c <= 8) ? 8 : ((c <= 12) ? 0 : 20));
            check("s3_grant", grant, (c <= 8) ? 4'b1000 : ((c <= 12) ? 4'b0000 : 4'b0001));
            check("s3_busy", busy, 1);
            if (c == 1) req = 4'b1001;
        end

        // Pause mid-hold freezes the counter and mutes
        do_reset();
        set_notes(0, 12, 0, 0);
        req = 4'b0010;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c <= 3 || (c >= 14 && c <= 18)) begin
                check("s4_note", note_out, 12);
                check("s4_grant", grant, 4'b0010);
            end else if (c <= 13) begin
                check("s4_pause_note", note_out, 0);
                check("s4_pause_grant", grant, 4'b0010);
            end else begin
                check("s4_gap_note", note_out, 0);
                check("s4_gap_grant", grant, 0);
                check("s4_gap_busy", busy, 1);
            end
            if (c == 3) pause = 1'b1;
            if (c == 13) begin
                pause = 1'b0;
                req   = 4'b0000;
            end
        end

        // Owner disabled: immediate gap, no hold extension
        do_reset();
        set_notes(0, 0, 7, 0);
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 3) begin
                check("s5_note", note_out, 7);
            end else if (c <= 7) begin
                check("s5_gap_note", note_out, 0);
                check("s5_gap_grant", grant, 0);
                check("s5_gap_busy", busy, 1);
            end else begin
                check("s5_idle_busy", busy, 0);
            end
            if (c == 3) src_en = 4'b1011;
        end

        // Simultaneous requests, owner released each round
`ifdef BUZZER_ARB_RR_EN
        exp2 = 4'b1000;
`else
        exp2 = 4'b0010;
`endif
        do_reset();
        set_notes(0, 3, 0, 9);
        req = 4'b1010;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) begin
                check("s6_grant1", grant, 4'b0010);
                check("s6_note1", note_out, 3);
                req = 4'b1000;
            end
            if (c == 9) req = 4'b1010;
            if (c == 13) begin
                check("s6_grant2", grant, exp2);
                check("s6_note2", note_out, (exp2 == 4'b1000) ? 9 : 3);
                req = 4'b1010 & ~exp2;
            end
            if (c == 21) req = 4'b1010;
            if (c == 25) check("s6_grant3", grant, 4'b0010);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
